// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave register file.
//   spi_slv_state_t : frame FSM states
//   CMD_WR_BIT      : command-byte bit selecting write (1) or read (0)
//   FRAME_BITS      : bits per frame at the default 8-bit data width
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } spi_slv_state_t;

    localparam int SPI_DW     = 8;
    localparam int CMD_WR_BIT = 7;
    localparam int FRAME_BITS = 2 * SPI_DW;

endpackage

// File: rtl/spi_slv_shift.sv
// Generic shift register with parallel load and serial input (MSB shifts out first).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : parallel load (has priority over shift)
//   load_val_i   : value loaded when load_i is high
//   shift_i      : shift left by one, ser_i enters at bit 0
//   ser_i        : serial input
//   q_o          : current register contents
module spi_slv_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    input  logic         ser_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i)
            sr_d = load_val_i;
        else if (shift_i)
            sr_d = {sr_q[W-2:0], ser_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sr_q <= '0;
        else
            sr_q <= sr_d;
    end

    assign q_o = sr_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave decoding 16-bit frames (command byte, data byte, MSB first) into
// reads/writes of a small register file exposed as parallel outputs.
// Optional feature macro: SPI_SLV_STATUS_EN -- the master reads a status byte
// {1, err_sticky, 00, wr_cnt[3:0]} on MISO during the command byte.
// Ports:
//   SCK        : clock, all flops on its rising edge
//   reset      : asynchronous active-low reset
//   SSB        : slave select, active low
//   MOSI/MISO  : serial data in/out, MSB first
//   regs_out   : register file, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_strobe  : one-cycle pulse after a write commits, wr_addr holds the index
//   frame_err  : one-cycle pulse when SSB rises mid-frame
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                           SCK,
    input  logic                           reset,
    input  logic                           SSB,
    input  logic                           MOSI,
    output logic                           MISO,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic                           wr_strobe,
    output logic [ADDR_W-1:0]              wr_addr,
    output logic                           frame_err
);

    localparam int FRAME_N = 2 * DATA_WIDTH;
    localparam int CNT_W   = $clog2(FRAME_N + 1);
    localparam logic [DATA_WIDTH-2:0] NREGS_A = (DATA_WIDTH-1)'(NUM_REGS);

    spi_slv_state_t                          state_q, state_d;
    logic [CNT_W-1:0]                        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]                   cmd_q, cmd_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]     regs_q, regs_d;
    logic                                    wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]                       wr_addr_q, wr_addr_d;
    logic                                    frame_err_q, frame_err_d;

    logic [DATA_WIDTH-1:0] rx_q, tx_q, tx_val, rx_word;
    logic                  tx_load, abort, new_map, cmd_map;

    // Completed byte on the current edge: 7 stored bits plus the live MOSI bit.
    assign rx_word = {rx_q[DATA_WIDTH-2:0], MOSI};
    assign new_map = rx_word[DATA_WIDTH-2:0] < NREGS_A;
    assign cmd_map = cmd_q[DATA_WIDTH-2:0] < NREGS_A;
    assign abort   = SSB && (state_q == CMD || state_q == DATA);

`ifdef SPI_SLV_STATUS_EN
    logic                  err_sticky_q;
    logic [3:0]            wr_cnt_q;
    logic [DATA_WIDTH-1:0] status_w;

    assign status_w = DATA_WIDTH'({1'b1, err_sticky_q, 2'b00, wr_cnt_q});

    always_ff @(posedge SCK or negedge reset) begin
        if (!reset) begin
            err_sticky_q <= 1'b0;
            wr_cnt_q     <= '0;
        end else begin
            err_sticky_q <= err_sticky_q | abort;
            wr_cnt_q     <= wr_cnt_q + {3'b000, wr_strobe_d};
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = abort;
        tx_load     = 1'b0;
        tx_val      = '0;
        if (SSB) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            if (cnt_q != CNT_W'(FRAME_N))
                cnt_d = cnt_q + CNT_W'(1);
            case (state_q)
                IDLE: state_d = CMD;
                CMD: if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = DATA;
                    cmd_d   = rx_word;
                    if (!rx_word[CMD_WR_BIT]) begin
                        tx_load = 1'b1;
                        tx_val  = new_map ? regs_q[rx_word[ADDR_W-1:0]] : '0;
                    end
                end
                DATA: if (cnt_q == CNT_W'(FRAME_N - 1)) begin
                    state_d = DONE;
                    if (cmd_q[CMD_WR_BIT] && cmd_map) begin
                        regs_d[cmd_q[ADDR_W-1:0]] = rx_word;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = cmd_q[ADDR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
`ifdef SPI_SLV_STATUS_EN
        // Reload status on every idle edge between frames; the first frame edge
        // then shifts it, so MISO already shows the MSB before that edge.
        if (state_q == IDLE && SSB) begin
            tx_load = 1'b1;
            tx_val  = status_w;
        end
`endif
    end

    always_ff @(posedge SCK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    spi_slv_shift #(.W(DATA_WIDTH)) u_rx (
        .clk(SCK), .rst_n(reset), .load_i(1'b0), .load_val_i('0),
        .shift_i(!SSB), .ser_i(MOSI), .q_o(rx_q)
    );

    spi_slv_shift #(.W(DATA_WIDTH)) u_tx (
        .clk(SCK), .rst_n(reset), .load_i(tx_load), .load_val_i(tx_val),
        .shift_i(!SSB), .ser_i(1'b0), .q_o(tx_q)
    );

    // MISO is gated by SSB directly so it drops as soon as the master deselects.
    always_comb begin
        MISO = 1'b0;
        if (!SSB) begin
            case (state_q)
`ifdef SPI_SLV_STATUS_EN
                IDLE, CMD: MISO = tx_q[DATA_WIDTH-1];
`endif
                DATA:    MISO = ~cmd_q[CMD_WR_BIT] & tx_q[DATA_WIDTH-1];
                default: MISO = 1'b0;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{rx_q[DATA_WIDTH-1], tx_q[DATA_WIDTH-2:0]};

    assign regs_out  = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: directed frames plus randomized
// frames, compared against a register-array model of the slave.
module tb_spi_slave_regfile;
    import spi_pkg::*;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int AW = 2;

    logic             SCK = 1'b0;
    logic             reset, SSB, MOSI, MISO, wr_strobe, frame_err;
    logic [NR*DW-1:0] regs_out;
    logic [AW-1:0]    wr_addr;

    int            n_chk = 0, n_fail = 0, n_strobe = 0, n_err = 0;
    logic [AW-1:0] last_wa = '0;

    logic [DW-1:0] m_regs [NR];
    logic          m_err;
    logic [3:0]    m_wcnt;

    spi_slave_regfile #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .SCK(SCK), .reset(reset), .SSB(SSB), .MOSI(MOSI), .MISO(MISO),
        .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .frame_err(frame_err)
    );

    always #5 SCK = ~SCK;

    // Pulse counters sampled mid-cycle; a pulse longer than one cycle counts twice.
    always @(negedge SCK) begin
        if (wr_strobe === 1'b1) begin
            n_strobe++;
            last_wa = wr_addr;
        end
        if (frame_err === 1'b1) n_err++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_pack();
        logic [NR*DW-1:0] p;
        for (int i = 0; i < NR; i++) p[i*DW +: DW] = m_regs[i];
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_err  = 1'b0;
        m_wcnt = '0;
    endtask

    // Drive nbits of {cmd, dat, random tail}, record what the master sees on MISO
    // at each edge, then deselect and check the outcome against the model.
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] dat,
                             input int nbits, output logic [23:0] miso_v);
        logic [23:0] fr, exp_v, mask, all1;
        int          s0, e0, exp_s, exp_e, a;
        logic        mapped;
        fr     = {cmd, dat, 8'($urandom)};
        exp_v  = '0;
        miso_v = '0;
        all1   = '1;
        mask   = ~(all1 >> nbits);
        a      = int'(cmd[6:0]);
        mapped = a < NR;
`ifdef SPI_SLV_STATUS_EN
        exp_v[23:16] = {1'b1, m_err, 2'b00, m_wcnt};
`endif
        if (!cmd[7]) exp_v[15:8] = mapped ? m_regs[a] : 8'h00;
        exp_s = (nbits >= FRAME_BITS && cmd[7] && mapped) ? 1 : 0;
        exp_e = (nbits >= 1 && nbits < FRAME_BITS) ? 1 : 0;
        s0 = n_strobe;
        e0 = n_err;
        @(posedge SCK); #1;
        SSB = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            MOSI = fr[23-k];
            @(negedge SCK);
            miso_v[23-k] = MISO;
            @(posedge SCK); #1;
        end
        SSB  = 1'b1;
        MOSI = 1'b0;
        repeat (2) @(posedge SCK);
        #1;
        if (exp_s == 1) begin
            m_regs[a] = dat;
            m_wcnt    = m_wcnt + 4'd1;
        end
        if (exp_e == 1) m_err = 1'b1;
        chk($sformatf("miso c%02h n%0d", cmd, nbits), miso_v & mask, exp_v & mask);
        chk($sformatf("strobe c%02h n%0d", cmd, nbits), n_strobe - s0, exp_s);
        chk($sformatf("ferr c%02h n%0d", cmd, nbits), n_err - e0, exp_e);
        chk($sformatf("regs c%02h n%0d", cmd, nbits), regs_out, model_pack());
        if (exp_s == 1) chk($sformatf("wr_addr c%02h", cmd), last_wa, cmd[AW-1:0]);
    endtask

    initial begin
        logic [23:0] mv;
        logic [15:0] fr;
        logic [7:0]  c, d;
        int          nb;

        reset = 1'b0;
        SSB   = 1'b1;
        MOSI  = 1'b0;
        model_reset();
        #12;
        chk("rst regs", regs_out, '0);
        chk("rst miso", MISO, 1'b0);
        chk("rst strobe", wr_strobe, 1'b0);
        chk("rst wr_addr", wr_addr, '0);
        chk("rst ferr", frame_err, 1'b0);
        @(negedge SCK) reset = 1'b1;
        repeat (2) @(posedge SCK);
        #1;

        // Write reg1, read it back, unmapped write and read.
        run_frame(8'h81, 8'h22, 16, mv);
        chk("reg1 byte", regs_out[15:8], 8'h22);
        run_frame(8'h01, 8'h00, 16, mv);
        chk("read reg1", mv[15:8], 8'h22);
        run_frame(8'h85, 8'h5A, 16, mv);
        run_frame(8'h05, 8'h00, 16, mv);
        chk("read unmapped", mv[15:8], 8'h00);

        // Abort after 12 bits of a write, then a clean frame.
        run_frame(8'h82, 8'hFF, 12, mv);
        chk("reg2 after abort", regs_out[23:16], 8'h00);
        run_frame(8'h01, 8'h00, 16, mv);

        // Status byte reflects one write and one abort so far.
        run_frame(8'h00, 8'h00, 16, mv);
`ifdef SPI_SLV_STATUS_EN
        chk("status byte", mv[23:16], 8'hC1);
`endif

        // Reset in the middle of a write's data byte.
        fr = {8'h83, 8'hA5};
        @(posedge SCK); #1;
        SSB = 1'b0;
        for (int k = 0; k < 12; k++) begin
            MOSI = fr[15-k];
            @(posedge SCK); #1;
        end
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst regs", regs_out, '0);
        chk("midrst miso", MISO, 1'b0);
        chk("midrst strobe", wr_strobe, 1'b0);
        chk("midrst wr_addr", wr_addr, '0);
        chk("midrst ferr", frame_err, 1'b0);
        SSB  = 1'b1;
        MOSI = 1'b0;
        repeat (2) @(posedge SCK);
        #1 reset = 1'b1;
        repeat (2) @(posedge SCK);
        #1;
        run_frame(8'h83, 8'h3C, 16, mv);
        chk("reg3 byte", regs_out[31:24], 8'h3C);

        // Randomized frames: mixed reads/writes, some unmapped, some short or long.
        for (int i = 0; i < 40; i++) begin
            c  = {1'($urandom), 7'($urandom_range(0, NR + 2))};
            d  = 8'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : FRAME_BITS;
            run_frame(c, d, nb, mv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
